dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder (memory-side end) of the MEM-stage data-memory request interface driven by the pipelined core: accepts one load/store request at a time, performs byte/halfword/word access with RISC-V func3 semantics, returns a handshaked response after a programmable wait-state latency.
- Sits between the EX/MEM pipeline register and a word-organised data RAM.
- Replaces the fixed single-cycle data memory so that slow memories can be modelled; the core stalls on req_ready/rsp_valid.

Parameters:
- DM_ADDRESS, 9, byte-address width; RAM holds 2**(DM_ADDRESS-2) 32-bit words.
- DATA_W, 32, data width; fixed at 32, other values unsupported.
- WAIT_CYCLES, 1, extra read-latency cycles, legal range 0..7.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request (IDLE only).
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  DM_ADDRESS  byte address.
- req_wdata  in  DATA_W  store data; low bytes used for SB/SH.
- req_func3  in  3  RISC-V funct3 of the load/store.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core consumes the response.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned access or illegal func3.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, wait counter=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. RAM contents are not cleared.
- After reset release: req_ready=1 in IDLE.
- FSM states:
  - IDLE: req_ready=1. Acceptance requires req_valid && req_ready at a rising edge; the request fields are latched on that edge.
  - IDLE -> RESP: on an accepted store or an errored request.
  - IDLE -> WAIT: on an accepted legal load with WAIT_CYCLES>0.
  - IDLE -> RESP: on an accepted legal load with WAIT_CYCLES=0.
  - WAIT: the counter counts WAIT_CYCLES edges. The RAM word is read on the final edge, then the state moves to RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready=1 at an edge, then the state moves to IDLE.
  - RESP -> IDLE: rsp_valid drops on the next cycle; no back-to-back acceptance in the same edge.
- Latency: rsp_valid rises 1 cycle after acceptance for stores and errors, and WAIT_CYCLES+1 cycles after acceptance for loads.
- Single outstanding request: a read after a write always sees the written data.
- Stores: byte lanes are written on the acceptance edge.
  - SB (func3=0) writes lane addr[1:0].
  - SH (1) writes lanes {addr[1],0}.
  - SW (2) writes all 4 lanes.
  - rsp_rdata=0.
- Loads: select a byte or halfword by addr[1:0] from the word at addr[DM_ADDRESS-1:2].
  - LB (0): sign-extend the byte.
  - LH (1): sign-extend the halfword.
  - LW (2): full word.
  - LBU (4): zero-extend the byte.
  - LHU (5): zero-extend the halfword.
- Errors: no RAM write, rsp_rdata=0, rsp_err=1. Error conditions:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Load func3 in {3,6,7}.
  - Store func3 >2.
- req_valid is ignored outside IDLE. Request inputs may change freely after acceptance.
- rsp_ready high while rsp_valid=0 has no effect.
- Reset asserted mid-WAIT or mid-RESP: the pending response is discarded and the FSM returns to IDLE. A store already written stays written.
- Little-endian byte order.

Test Plan:
- Reset pulse then release, no requests -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- SW addr 0x010 data 0xDEADBEEF, then LW 0x010 with WAIT_CYCLES=1 -> write rsp_valid 1 cycle after acceptance with rdata=0, err=0; read rsp_valid exactly 2 cycles after acceptance with rdata=0xDEADBEEF.
- After that store, loads:
  - LB 0x013 -> 0xFFFFFFDE.
  - LBU 0x012 -> 0x000000AD.
  - LH 0x012 -> 0xFFFFDEAD.
  - LHU 0x010 -> 0x0000BEEF.
- SB 0x011 data 0x00000055, then LW 0x010 -> 0xDEAD55EF; SH 0x012 data 0x1234 then LW 0x010 -> 0x123455EF.
- Error cases, each -> rsp_err=1, rdata=0; a following LW 0x010 still returns 0xDEADBEEF:
  - LW 0x011.
  - LH 0x013.
  - func3=3 load.
  - SW 0x012 data 0xFFFFFFFF.
- Hold rsp_ready=0 for 5 cycles on a load response -> rsp_valid/rdata stable, req_ready=0, new req_valid ignored.
- Assert reset during WAIT -> rsp_valid=0 immediately, IDLE after release.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the MEM-stage data request
// interface. One request at a time, RV32 byte/half/word load/store, with
// WAIT_CYCLES extra load latency and a valid/ready response handshake.
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_func3 : request side
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                  : response side
module dmem_responder #(
   parameter int DM_ADDRESS  = 9,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [DM_ADDRESS-1:0] req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [2:0]            req_func3,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err
);

   localparam int WORDS = 2 ** (DM_ADDRESS - 2);
   localparam logic [2:0] CNT_LAST =
      3'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t                state_q;
   logic [2:0]            cnt_q;
   logic [DM_ADDRESS-1:0] addr_q;
   logic [2:0]            f3_q;
   logic                  ready_q;
   logic                  valid_q;
   logic [31:0]           rdata_q;
   logic                  err_q;

   logic [31:0] mem [WORDS];

   logic                  accept;
   logic                  req_err;
   logic [3:0]            be;
   logic [31:0]           wd;
   logic                  wr_en;
   logic [DM_ADDRESS-1:0] ld_addr;
   logic [2:0]            ld_f3;
   logic [31:0]           ld_word;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [31:0]           ld_data;

   assign accept = req_valid && ready_q;

   // func3[1:0] encodes access size for both loads and stores
   always_comb begin
      req_err = 1'b0;
      if (req_we) begin
         req_err = (req_func3 > 3'd2);
      end else begin
         req_err = (req_func3 == 3'd3) || (req_func3 == 3'd6) ||
                   (req_func3 == 3'd7);
      end
      case (req_func3[1:0])
         2'd1: if (req_addr[0]) req_err = 1'b1;
         2'd2: if (req_addr[1:0] != 2'd0) req_err = 1'b1;
         default: ;
      endcase
   end

   // store data is replicated across lanes; byte enables pick the target
   always_comb begin
      be = 4'b0000;
      wd = req_wdata;
      case (req_func3[1:0])
         2'd0: begin
            be = 4'b0001 << req_addr[1:0];
            wd = {4{req_wdata[7:0]}};
         end
         2'd1: begin
            be = req_addr[1] ? 4'b1100 : 4'b0011;
            wd = {2{req_wdata[15:0]}};
         end
         default: be = 4'b1111;
      endcase
   end

   assign wr_en = accept && req_we && !req_err;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[req_addr[DM_ADDRESS-1:2]][8*i +: 8] <= wd[8*i +: 8];
         end
      end
   end

   // zero-wait loads read straight from the request; otherwise from latches
   assign ld_addr = (state_q == S_IDLE) ? req_addr : addr_q;
   assign ld_f3   = (state_q == S_IDLE) ? req_func3 : f3_q;
   assign ld_word = mem[ld_addr[DM_ADDRESS-1:2]];
   assign ld_byte = 8'(ld_word >> {ld_addr[1:0], 3'b000});
   assign ld_half = ld_addr[1] ? ld_word[31:16] : ld_word[15:0];

   always_comb begin
      ld_data = 32'd0;
      case (ld_f3)
         3'd0: ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'd1: ld_data = {{16{ld_half[15]}}, ld_half};
         3'd2: ld_data = ld_word;
         3'd4: ld_data = {24'd0, ld_byte};
         3'd5: ld_data = {16'd0, ld_half};
         default: ld_data = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         addr_q  <= '0;
         f3_q    <= 3'd0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               ready_q <= 1'b1;
               if (accept) begin
                  ready_q <= 1'b0;
                  addr_q  <= req_addr;
                  f3_q    <= req_func3;
                  cnt_q   <= 3'd0;
                  if (req_we || req_err) begin
                     state_q <= S_RESP;
                     valid_q <= 1'b1;
                     rdata_q <= 32'd0;
                     err_q   <= req_err;
                  end else if (WAIT_CYCLES == 0) begin
                     state_q <= S_RESP;
                     valid_q <= 1'b1;
                     rdata_q <= ld_data;
                     err_q   <= 1'b0;
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_q == CNT_LAST) begin
                  state_q <= S_RESP;
                  cnt_q   <= 3'd0;
                  valid_q <= 1'b1;
                  rdata_q <= ld_data;
                  err_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 3'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state_q <= S_IDLE;
                  valid_q <= 1'b0;
                  rdata_q <= 32'd0;
                  err_q   <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven bench for dmem_responder (WAIT_CYCLES=1)
// plus directed back-pressure and mid-wait reset sequences.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [8:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [2:0]  req_func3 = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int checks = 0;
   int errors = 0;

   dmem_responder #(
      .DM_ADDRESS (9),
      .DATA_W     (32),
      .WAIT_CYCLES(1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we   (req_we),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .req_func3(req_func3),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        we;
      logic [8:0]  addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_req(input vec_t v);
      int lat;
      @(negedge clk);
      chk({v.name, "_rdy"}, 32'(req_ready), 32'd1);
      req_we    = v.we;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      req_func3 = v.f3;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_wdata = '0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({v.name, "_lat"}, 32'(lat), 32'(v.exp_lat));
      chk({v.name, "_rdata"}, rsp_rdata, v.exp_rdata);
      chk({v.name, "_err"}, 32'(rsp_err), 32'(v.exp_err));
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk({v.name, "_drop"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      vec_t v;
      int   lat;

      vecs[0]  = '{"sw_010",   1'b1, 9'h010, 32'hDEADBEEF, 3'd2, 32'h0,        1'b0, 1};
      vecs[1]  = '{"lw_010",   1'b0, 9'h010, 32'h0,        3'd2, 32'hDEADBEEF, 1'b0, 2};
      vecs[2]  = '{"lb_013",   1'b0, 9'h013, 32'h0,        3'd0, 32'hFFFFFFDE, 1'b0, 2};
      vecs[3]  = '{"lbu_012",  1'b0, 9'h012, 32'h0,        3'd4, 32'h000000AD, 1'b0, 2};
      vecs[4]  = '{"lh_012",   1'b0, 9'h012, 32'h0,        3'd1, 32'hFFFFDEAD, 1'b0, 2};
      vecs[5]  = '{"lhu_010",  1'b0, 9'h010, 32'h0,        3'd5, 32'h0000BEEF, 1'b0, 2};
      vecs[6]  = '{"lw_011e",  1'b0, 9'h011, 32'h0,        3'd2, 32'h0,        1'b1, 1};
      vecs[7]  = '{"lh_013e",  1'b0, 9'h013, 32'h0,        3'd1, 32'h0,        1'b1, 1};
      vecs[8]  = '{"ld_f3_3e", 1'b0, 9'h010, 32'h0,        3'd3, 32'h0,        1'b1, 1};
      vecs[9]  = '{"sw_012e",  1'b1, 9'h012, 32'hFFFFFFFF, 3'd2, 32'h0,        1'b1, 1};
      vecs[10] = '{"lw_after", 1'b0, 9'h010, 32'h0,        3'd2, 32'hDEADBEEF, 1'b0, 2};
      vecs[11] = '{"sb_011",   1'b1, 9'h011, 32'h00000055, 3'd0, 32'h0,        1'b0, 1};
      vecs[12] = '{"lw_sb",    1'b0, 9'h010, 32'h0,        3'd2, 32'hDEAD55EF, 1'b0, 2};
      vecs[13] = '{"sh_012",   1'b1, 9'h012, 32'h00001234, 3'd1, 32'h0,        1'b0, 1};
      vecs[14] = '{"lw_sh",    1'b0, 9'h010, 32'h0,        3'd2, 32'h123455EF, 1'b0, 2};
      vecs[15] = '{"st_f3_4e", 1'b1, 9'h010, 32'hFFFFFFFF, 3'd4, 32'h0,        1'b1, 1};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_ready", 32'(req_ready), 32'd1);
      chk("idle_valid", 32'(rsp_valid), 32'd0);
      chk("idle_rdata", rsp_rdata, 32'd0);
      chk("idle_err", 32'(rsp_err), 32'd0);

      for (int i = 0; i < 16; i++) do_req(vecs[i]);

      // back-pressure: response held for 5 cycles, new request ignored
      @(negedge clk);
      req_addr  = 9'h010;
      req_func3 = 3'd2;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("bp_lat", 32'(lat), 32'd2);
      @(negedge clk);
      req_we    = 1'b1;
      req_addr  = 9'h010;
      req_wdata = 32'h0;
      req_func3 = 3'd2;
      req_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rdata", rsp_rdata, 32'h123455EF);
         chk("bp_ready", 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      req_valid = 1'b0;
      req_we    = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk("bp_drop", 32'(rsp_valid), 32'd0);
      v = '{"lw_post_bp", 1'b0, 9'h010, 32'h0, 3'd2, 32'h123455EF, 1'b0, 2};
      do_req(v);

      // reset asserted while waiting for the RAM read
      @(negedge clk);
      req_addr  = 9'h010;
      req_func3 = 3'd2;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("wr_in_wait", 32'(rsp_valid), 32'd0);
      #1;
      reset = 1'b0;
      #1;
      chk("wr_valid", 32'(rsp_valid), 32'd0);
      chk("wr_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("wr_idle_ready", 32'(req_ready), 32'd1);
      chk("wr_idle_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("wr_no_stale", 32'(rsp_valid), 32'd0);
      v = '{"lw_post_rst", 1'b0, 9'h010, 32'h0, 3'd2, 32'h123455EF, 1'b0, 2};
      do_req(v);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
